// File: rtl/store_unit.sv
// Store path for the rv32i softcore: effective address, lane placement,
// and one or two aligned write beats per store on a valid/ready bus.
module store_unit #(
   parameter int XLEN           = 32,
   parameter bit ALLOW_MISALIGN = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [XLEN-1:0]   rs1_data,
   input  logic [XLEN-1:0]   rs2_data,
   input  logic [XLEN-1:0]   imm,
   input  logic [2:0]        funct3,
   output logic              bus_valid,
   input  logic              bus_ready,
   output logic [XLEN-1:0]   bus_addr,
   output logic [XLEN-1:0]   bus_wdata,
   output logic [XLEN/8-1:0] bus_wstrb,
   input  logic              bus_ack,
   input  logic              bus_err,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code,
   output logic              busy
);

   localparam int BYTES = XLEN / 8;
   localparam int OW    = $clog2(BYTES);

   typedef enum logic [2:0] {
      IDLE, BEAT0, WAIT0, BEAT1, WAIT1, DONE, FAULT
   } state_t;

   state_t            state, state_n;
   logic [1:0]        code_q, code_n;
   logic [XLEN-1:0]   addr_q, data_q;
   logic [1:0]        lsz_q;

   logic              accept;
   logic [XLEN-1:0]   ea;
   logic [XLEN-1:0]   data_m;
   logic [4:0]        in_size;
   logic [3:0]        in_amask;
   logic              illegal, misal;

   logic [OW-1:0]     off;
   logic [OW:0]       rem;
   logic [4:0]        size_q;
   logic              split;
   logic [XLEN-1:0]   base;
   logic [2*BYTES-1:0] mask;

   assign accept   = in_valid && (state == IDLE);
   assign ea       = rs1_data + imm;
   assign in_size  = 5'd1 << funct3[1:0];
   assign in_amask = in_size[3:0] - 4'd1;
   assign illegal  = funct3[2] ||
                     ((funct3[1:0] == 2'b11) && (XLEN == 32));
   assign misal    = (ea[3:0] & in_amask) != 4'd0;

   // Bytes beyond the store size are zeroed so unused lanes stay clean
   always_comb begin
      data_m = '0;
      for (int i = 0; i < BYTES; i++) begin
         if (i < int'(in_size))
            data_m[8*i +: 8] = rs2_data[8*i +: 8];
      end
   end

   assign off    = addr_q[OW-1:0];
   assign rem    = (OW+1)'(BYTES) - {1'b0, off};
   assign size_q = 5'd1 << lsz_q;
   assign split  = (5'(off) + size_q) > 5'(BYTES);
   assign base   = {addr_q[XLEN-1:OW], {OW{1'b0}}};
   assign mask   = ~({(2*BYTES){1'b1}} << size_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         code_q <= 2'd0;
         addr_q <= '0;
         data_q <= '0;
         lsz_q  <= 2'd0;
      end else begin
         state  <= state_n;
         code_q <= code_n;
         if (accept) begin
            addr_q <= ea;
            data_q <= data_m;
            lsz_q  <= funct3[1:0];
         end
      end
   end

   always_comb begin
      state_n = state;
      code_n  = code_q;
      case (state)
         IDLE: begin
            if (accept) begin
               if (illegal) begin
                  state_n = FAULT;
                  code_n  = 2'd1;
               end else if (!ALLOW_MISALIGN && misal) begin
                  state_n = FAULT;
                  code_n  = 2'd2;
               end else begin
                  state_n = BEAT0;
                  code_n  = 2'd0;
               end
            end
         end
         BEAT0: if (bus_ready) state_n = WAIT0;
         WAIT0: begin
            if (bus_ack) begin
               if (bus_err) begin
                  state_n = DONE;
                  code_n  = 2'd3;
               end else if (split) begin
                  state_n = BEAT1;
               end else begin
                  state_n = DONE;
                  code_n  = 2'd0;
               end
            end
         end
         BEAT1: if (bus_ready) state_n = WAIT1;
         WAIT1: begin
            if (bus_ack) begin
               state_n = DONE;
               code_n  = bus_err ? 2'd3 : 2'd0;
            end
         end
         DONE:    state_n = IDLE;
         FAULT:   state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // Bus outputs are decoded from state so reset clears them at once
   always_comb begin
      bus_valid = 1'b0;
      bus_addr  = '0;
      bus_wdata = '0;
      bus_wstrb = '0;
      case (state)
         BEAT0: begin
            bus_valid = 1'b1;
            bus_addr  = base;
            bus_wdata = data_q << {off, 3'b000};
            bus_wstrb = BYTES'(mask << off);
         end
         BEAT1: begin
            bus_valid = 1'b1;
            bus_addr  = base + XLEN'(BYTES);
            bus_wdata = data_q >> {rem, 3'b000};
            bus_wstrb = BYTES'(mask >> rem);
         end
         default: ;
      endcase
   end

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);
   assign done     = (state == DONE) || (state == FAULT);
   assign err_code = done ? code_q : 2'd0;
   assign err      = done && (code_q != 2'd0);

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit: 32-bit split/unsplit instances,
// a fault-only instance and a 64-bit instance with mid-store reset.
module tb_store_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n, rst64_n;
   logic [31:0] rs1, rs2, imm;
   logic [2:0]  funct3;
   logic        va, vb;
   logic        bready, back, berr;

   logic        a_rdy, a_bv, a_done, a_err, a_busy;
   logic [31:0] a_addr, a_wd;
   logic [3:0]  a_st;
   logic [1:0]  a_ec;

   logic        b_rdy, b_bv, b_done, b_err, b_busy;
   logic [31:0] b_addr, b_wd;
   logic [3:0]  b_st;
   logic [1:0]  b_ec;

   logic [63:0] rs1_64, rs2_64, imm_64;
   logic [2:0]  f3_64;
   logic        v64, rdy64, ack64, err64;
   logic        c_rdy, c_bv, c_done, c_err, c_busy;
   logic [63:0] c_addr, c_wd;
   logic [7:0]  c_st;
   logic [1:0]  c_ec;

   store_unit #(.XLEN(32), .ALLOW_MISALIGN(1'b1)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(va), .in_ready(a_rdy),
      .rs1_data(rs1), .rs2_data(rs2), .imm(imm), .funct3(funct3),
      .bus_valid(a_bv), .bus_ready(bready), .bus_addr(a_addr),
      .bus_wdata(a_wd), .bus_wstrb(a_st), .bus_ack(back),
      .bus_err(berr), .done(a_done), .err(a_err), .err_code(a_ec),
      .busy(a_busy)
   );

   store_unit #(.XLEN(32), .ALLOW_MISALIGN(1'b0)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(vb), .in_ready(b_rdy),
      .rs1_data(rs1), .rs2_data(rs2), .imm(imm), .funct3(funct3),
      .bus_valid(b_bv), .bus_ready(bready), .bus_addr(b_addr),
      .bus_wdata(b_wd), .bus_wstrb(b_st), .bus_ack(back),
      .bus_err(berr), .done(b_done), .err(b_err), .err_code(b_ec),
      .busy(b_busy)
   );

   store_unit #(.XLEN(64), .ALLOW_MISALIGN(1'b1)) u_c (
      .clk(clk), .rst_n(rst64_n), .in_valid(v64), .in_ready(c_rdy),
      .rs1_data(rs1_64), .rs2_data(rs2_64), .imm(imm_64),
      .funct3(f3_64), .bus_valid(c_bv), .bus_ready(rdy64),
      .bus_addr(c_addr), .bus_wdata(c_wd), .bus_wstrb(c_st),
      .bus_ack(ack64), .bus_err(err64), .done(c_done), .err(c_err),
      .err_code(c_ec), .busy(c_busy)
   );

   int n_run  = 0;
   int n_fail = 0;

   int          nbeat;
   int          done_cyc;
   logic [31:0] bt_addr [2];
   logic [31:0] bt_data [2];
   logic [3:0]  bt_strb [2];
   logic        r_err;
   logic [1:0]  r_code;

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Zero-wait store on u_a; beats and done status land in bt_*/r_*
   task automatic run_a(input logic [31:0] b, input logic [31:0] o,
                        input logic [31:0] d, input logic [2:0] f);
      logic pend;
      pend     = 1'b0;
      nbeat    = 0;
      done_cyc = -1;
      r_err    = 1'b0;
      r_code   = 2'd0;
      @(negedge clk);
      rs1 = b; imm = o; rs2 = d; funct3 = f;
      va = 1'b1; bready = 1'b1; back = 1'b0; berr = 1'b0;
      @(posedge clk);
      #1 va = 1'b0;
      for (int c = 1; c <= 20 && done_cyc < 0; c++) begin
         @(negedge clk);
         back = pend;
         pend = a_bv;
         if (a_bv && nbeat < 2) begin
            bt_addr[nbeat] = a_addr;
            bt_data[nbeat] = a_wd;
            bt_strb[nbeat] = a_st;
            nbeat++;
         end
         if (a_done) begin
            done_cyc = c;
            r_err    = a_err;
            r_code   = a_ec;
         end
      end
      back = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; rst64_n = 1'b0;
      rs1 = '0; rs2 = '0; imm = '0; funct3 = '0;
      va = 1'b0; vb = 1'b0; bready = 1'b1; back = 1'b0; berr = 1'b0;
      rs1_64 = '0; rs2_64 = '0; imm_64 = '0; f3_64 = '0;
      v64 = 1'b0; rdy64 = 1'b1; ack64 = 1'b0; err64 = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_bv", a_bv, 1'b0);
      chk("rst_addr", a_addr, 32'h0);
      chk("rst_wd", a_wd, 32'h0);
      chk("rst_st", a_st, 4'h0);
      chk("rst_done", a_done, 1'b0);
      chk("rst_err", a_err, 1'b0);
      chk("rst_ec", a_ec, 2'd0);
      chk("rst_busy", a_busy, 1'b0);
      chk("rst_rdy", a_rdy, 1'b1);
      chk("rst_c_bv", c_bv, 1'b0);
      chk("rst_c_rdy", c_rdy, 1'b1);
      rst_n = 1'b1; rst64_n = 1'b1;

      run_a(32'h1000, 32'h0, 32'hAABBCCDD, 3'b010);
      chk("sw_nbeat", nbeat, 1);
      chk("sw_addr", bt_addr[0], 32'h1000);
      chk("sw_wd", bt_data[0], 32'hAABBCCDD);
      chk("sw_st", bt_strb[0], 4'b1111);
      chk("sw_cyc", done_cyc, 3);
      chk("sw_err", r_err, 1'b0);

      run_a(32'h2000, 32'h3, 32'h000000EE, 3'b000);
      chk("sb_nbeat", nbeat, 1);
      chk("sb_addr", bt_addr[0], 32'h2000);
      chk("sb_wd", bt_data[0], 32'hEE000000);
      chk("sb_st", bt_strb[0], 4'b1000);
      chk("sb_cyc", done_cyc, 3);

      run_a(32'h1000, 32'h2, 32'hAABBCCDD, 3'b010);
      chk("spl_nbeat", nbeat, 2);
      chk("spl_a0", bt_addr[0], 32'h1000);
      chk("spl_d0", bt_data[0], 32'hCCDD0000);
      chk("spl_s0", bt_strb[0], 4'b1100);
      chk("spl_a1", bt_addr[1], 32'h1004);
      chk("spl_d1", bt_data[1], 32'h0000AABB);
      chk("spl_s1", bt_strb[1], 4'b0011);
      chk("spl_cyc", done_cyc, 5);
      chk("spl_err", r_err, 1'b0);

      run_a(32'h0, 32'hFFFFFFFE, 32'hAABBCCDD, 3'b010);
      chk("wrap_nbeat", nbeat, 2);
      chk("wrap_a0", bt_addr[0], 32'hFFFFFFFC);
      chk("wrap_d0", bt_data[0], 32'hCCDD0000);
      chk("wrap_a1", bt_addr[1], 32'h0);
      chk("wrap_d1", bt_data[1], 32'h0000AABB);
      chk("wrap_s1", bt_strb[1], 4'b0011);
      chk("wrap_ec", r_code, 2'd0);

      run_a(32'h1000, 32'h0, 32'h1, 3'b011);
      chk("ill_nbeat", nbeat, 0);
      chk("ill_cyc", done_cyc, 1);
      chk("ill_err", r_err, 1'b1);
      chk("ill_ec", r_code, 2'd1);

      @(negedge clk);
      rs1 = 32'h1000; imm = 32'h2; rs2 = 32'hAABBCCDD; funct3 = 3'b010;
      vb = 1'b1;
      @(posedge clk);
      #1 vb = 1'b0;
      @(negedge clk);
      chk("mis_done", b_done, 1'b1);
      chk("mis_err", b_err, 1'b1);
      chk("mis_ec", b_ec, 2'd2);
      chk("mis_bv", b_bv, 1'b0);
      @(negedge clk);
      chk("mis_done_off", b_done, 1'b0);
      chk("mis_rdy", b_rdy, 1'b1);

      @(negedge clk);
      rs1 = 32'h0FFF; imm = 32'h0; rs2 = 32'hDEAD1234; funct3 = 3'b001;
      va = 1'b1; bready = 1'b0; back = 1'b0; berr = 1'b0;
      @(posedge clk);
      #1 va = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         chk("stl_bv", a_bv, 1'b1);
         chk("stl_addr", a_addr, 32'h0FFC);
         chk("stl_wd", a_wd, 32'h34000000);
         chk("stl_st", a_st, 4'b1000);
      end
      @(negedge clk);
      chk("stl_bv4", a_bv, 1'b1);
      bready = 1'b1;
      @(negedge clk);
      chk("stl_wait_bv", a_bv, 1'b0);
      back = 1'b1; berr = 1'b1;
      @(negedge clk);
      back = 1'b0; berr = 1'b0;
      chk("stl_done", a_done, 1'b1);
      chk("stl_err", a_err, 1'b1);
      chk("stl_ec", a_ec, 2'd3);
      chk("stl_bv_d", a_bv, 1'b0);
      @(negedge clk);
      chk("stl_nob1", a_bv, 1'b0);
      chk("stl_idle", a_busy, 1'b0);

      @(negedge clk);
      rs1_64 = 64'h8; imm_64 = 64'h0; f3_64 = 3'b011;
      rs2_64 = 64'h1122334455667788;
      v64 = 1'b1;
      @(posedge clk);
      #1 v64 = 1'b0;
      @(negedge clk);
      chk("sd_bv", c_bv, 1'b1);
      chk("sd_addr", c_addr, 64'h8);
      chk("sd_wd", c_wd, 64'h1122334455667788);
      chk("sd_st", c_st, 8'hFF);
      @(negedge clk);
      ack64 = 1'b1;
      @(negedge clk);
      ack64 = 1'b0;
      chk("sd_done", c_done, 1'b1);
      chk("sd_err", c_err, 1'b0);

      @(negedge clk);
      rs1_64 = 64'h10;
      v64 = 1'b1;
      @(posedge clk);
      #1 v64 = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk("rstx_busy0", c_busy, 1'b1);
      #2 rst64_n = 1'b0;
      #1;
      chk("rstx_bv", c_bv, 1'b0);
      chk("rstx_busy", c_busy, 1'b0);
      chk("rstx_rdy", c_rdy, 1'b1);
      chk("rstx_addr", c_addr, 64'h0);
      @(negedge clk);
      rst64_n = 1'b1;
      @(negedge clk);
      chk("rstx_idle", c_bv, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
